// File: rtl/micro_op_queue_pkg.sv
// Shared decoder types: register ids (RegMap) and micro-op encoding plus
// micro-op queue defaults (DecoderTypes).
package RegMap;
  typedef enum logic [3:0] {
    RAX, RCX, RDX, RBX, RSP, RBP, RSI, RDI,
    R8,  R9,  R10, R11, R12, R13, R14, R15
  } reg_id_t;
endpackage

package DecoderTypes;
  import RegMap::*;

  typedef enum logic [3:0] {
    M_NOP, M_ADD, M_SUB, M_LD, M_ST, M_JMP, M_JCC, M_SYSCALL
  } micro_opcode_t;

  typedef struct packed {
    micro_opcode_t opcode;
    reg_id_t       dst;
    reg_id_t       src_a;
    reg_id_t       src_b;
    logic [31:0]   rip;
  } micro_op_t;

  localparam int UOPQ_DEPTH_DFLT = 16;
  localparam int UOPQ_ENQ_W_DFLT = 4;
  localparam int UOPQ_DEQ_W_DFLT = 2;
endpackage

// File: rtl/micro_op_queue_if.sv
// Decoder-to-queue enqueue bundle and queue-to-execute dequeue bundle.
// master = decoder/execute side, slave = the queue itself.
interface micro_op_queue_if #(
  parameter int ENQ_W = DecoderTypes::UOPQ_ENQ_W_DFLT,
  parameter int DEQ_W = DecoderTypes::UOPQ_DEQ_W_DFLT
);
  logic [$clog2(ENQ_W+1)-1:0]           enq_count;
  DecoderTypes::micro_op_t [ENQ_W-1:0]  enq_uops;
  logic                                 enq_ready;
  logic [$clog2(DEQ_W+1)-1:0]           deq_avail;
  DecoderTypes::micro_op_t [DEQ_W-1:0]  deq_uops;
  logic [$clog2(DEQ_W+1)-1:0]           deq_take;

  modport master (
    output enq_count, enq_uops, deq_take,
    input  enq_ready, deq_avail, deq_uops
  );

  modport slave (
    input  enq_count, enq_uops, deq_take,
    output enq_ready, deq_avail, deq_uops
  );
endinterface

// File: rtl/micro_op_queue_stats.sv
// Stall-cycle counter (saturating) and occupancy high-water mark.
// Only instantiated when MICRO_OP_QUEUE_STATS_EN is defined.
module micro_op_queue_stats #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                stall_cycles,
  output logic [$clog2(DEPTH+1)-1:0] high_water
);
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      high_water   <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (occupancy > high_water)      high_water   <= occupancy;
    end
  end
endmodule

// File: rtl/micro_op_queue.sv
// Circular micro-op buffer between decoder and execute; all-or-nothing enqueue,
// in-order multi-op dequeue, whole-queue flush. Optional stats: MICRO_OP_QUEUE_STATS_EN.
module micro_op_queue
  import DecoderTypes::*;
#(
  parameter int DEPTH = UOPQ_DEPTH_DFLT,
  parameter int ENQ_W = UOPQ_ENQ_W_DFLT,
  parameter int DEQ_W = UOPQ_DEQ_W_DFLT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  micro_op_queue_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       err_overflow
`ifdef MICRO_OP_QUEUE_STATS_EN
  ,
  output logic [31:0]                stat_stall_cycles,
  output logic [$clog2(DEPTH+1)-1:0] stat_high_water
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int EC_W  = $clog2(ENQ_W+1);
  localparam int DC_W  = $clog2(DEQ_W+1);

  micro_op_t        mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [OCC_W-1:0] occ;
  logic [EC_W-1:0]  enq_n;
  logic [DC_W-1:0]  deq_n;
  logic             enq_acc, enq_rej;

  // Readiness looks only at current occupancy: same-cycle dequeues never free room.
  assign bus.enq_ready = (occ <= OCC_W'(DEPTH - ENQ_W));
  assign bus.deq_avail = (occ >= OCC_W'(DEQ_W)) ? DC_W'(DEQ_W) : DC_W'(occ);
  assign occupancy     = occ;
  assign enq_n   = (bus.enq_count > EC_W'(ENQ_W)) ? EC_W'(ENQ_W) : bus.enq_count;
  assign deq_n   = (bus.deq_take > bus.deq_avail) ? bus.deq_avail : bus.deq_take;
  assign enq_acc = bus.enq_ready && (enq_n != '0);
  assign enq_rej = !bus.enq_ready && (bus.enq_count != '0);

  always_comb begin
    bus.deq_uops = '0;
    for (int i = 0; i < DEQ_W; i++) bus.deq_uops[i] = mem[head + PTR_W'(i)];
  end

  // NOTE: the storage array carries no reset; occupancy alone defines which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (!reset && !flush && enq_acc) begin
      for (int i = 0; i < ENQ_W; i++)
        if (EC_W'(i) < enq_n) mem[tail + PTR_W'(i)] <= bus.enq_uops[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      occ          <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (flush) begin
        head <= '0;
        tail <= '0;
        occ  <= '0;
      end else begin
        if (enq_acc) tail <= tail + PTR_W'(enq_n);
        head <= head + PTR_W'(deq_n);
        occ  <= occ + (enq_acc ? OCC_W'(enq_n) : '0) - OCC_W'(deq_n);
      end
      if (enq_rej) err_overflow <= 1'b1;
    end
  end

`ifdef MICRO_OP_QUEUE_STATS_EN
  micro_op_queue_stats #(.DEPTH(DEPTH)) u_stats (
    .clk          (clk),
    .reset        (reset),
    .stall        (enq_rej),
    .occupancy    (occ),
    .stall_cycles (stat_stall_cycles),
    .high_water   (stat_high_water)
  );
`endif

  // Illegal requests are clamped above; these flag them in simulation.
  assert property (@(posedge clk) disable iff (reset || flush)
                   bus.deq_take <= bus.deq_avail);
  assert property (@(posedge clk) disable iff (reset)
                   bus.enq_count <= EC_W'(ENQ_W));
endmodule
